// File: rtl/cla_seq_pkg.sv
// Shared constants for the sequential multi-precision adder.
package cla_seq_pkg;
  localparam int WORD_W = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_e;
endpackage

// File: rtl/cla_seq_adder_ctrl_if.sv
// Request/response bundle between a client and the sequential adder.
interface cla_seq_adder_ctrl_if
  import cla_seq_pkg::*;
#(
  parameter int WORDS = 4
);
  logic                      start;
  logic                      sub;
  logic [WORDS*WORD_W-1:0]   a;
  logic [WORDS*WORD_W-1:0]   b;
  logic                      busy;
  logic                      done;
  logic [WORDS*WORD_W-1:0]   result;
  logic                      carry_out;
  logic                      overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, carry_out, overflow
  );
endinterface

// File: rtl/cla_16bit.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups, group carries
// resolved by a second lookahead level.
module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_start,
  output logic [15:0] sum,
  output logic        carry_out
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate, group carries, then per-bit carries inside each group
  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = carry_start;
    gc[1] = gg[0] | (gp[0] & carry_start);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & carry_start);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) |
            (gp[2] & gp[1] & gp[0] & carry_start);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) |
            (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & carry_start);
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k]) |
                 (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign sum       = p ^ c;
  assign carry_out = gc[4];
endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Multi-precision add/subtract: one 16-bit CLA reused across WORDS slices,
// LSW first, with the carry chained through a register.
module cla_seq_adder_ctrl
  import cla_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input logic                clk,
  input logic                rst,
  cla_seq_adder_ctrl_if.slave bus
);
  localparam int W  = WORDS * WORD_W;
  localparam int CW = $clog2(WORDS) + 1;

  state_e          state_q, state_d;
  logic [W-1:0]    a_sh_q, b_sh_q, res_q, res_nx;
  logic [CW-1:0]   cnt_q;
  logic            carry_q, cout_q, ovf_q;
  logic            accept, last;
  logic [WORD_W-1:0] sum;
  logic            add_co;

  cla_16bit u_cla (
    .a           (a_sh_q[WORD_W-1:0]),
    .b           (b_sh_q[WORD_W-1:0]),
    .carry_start (carry_q),
    .sum         (sum),
    .carry_out   (add_co)
  );

  // New slice enters at the top; after WORDS shifts the LSW sits at bit 0
  if (WORDS == 1) begin : g_one
    assign res_nx = sum;
  end else begin : g_multi
    assign res_nx = {sum, res_q[W-1:WORD_W]};
  end

  assign last = (state_q == ST_RUN) && (cnt_q == CW'(WORDS - 1));

  // Next-state logic; start is honoured only when no operation is in flight
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        accept  = bus.start;
        state_d = bus.start ? ST_RUN : ST_IDLE;
      end
      ST_RUN:  if (last) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Operand capture, slice shifting and carry chaining
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_sh_q  <= bus.a;
      b_sh_q  <= bus.sub ? ~bus.b : bus.b;
      carry_q <= bus.sub;
      cnt_q   <= '0;
    end else if (state_q == ST_RUN) begin
      a_sh_q  <= a_sh_q >> WORD_W;
      b_sh_q  <= b_sh_q >> WORD_W;
      res_q   <= res_nx;
      carry_q <= add_co;
      cnt_q   <= cnt_q + CW'(1);
      if (last) begin
        // b_sh already holds the inverted operand for subtraction
        ovf_q  <= (a_sh_q[WORD_W-1] == b_sh_q[WORD_W-1]) && (sum[WORD_W-1] != a_sh_q[WORD_W-1]);
        cout_q <= add_co;
      end
    end
  end

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.result    = res_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
module tb_cla_seq_adder_ctrl;
  localparam int WORDS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  cla_seq_adder_ctrl_if #(.WORDS(WORDS)) bus ();

  cla_seq_adder_ctrl #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: plain wide arithmetic on the 64-bit values
  function automatic logic [65:0] model(input logic [63:0] xa, input logic [63:0] xb, input logic xs);
    logic [64:0]        u;
    logic signed [65:0] s;
    logic               co, ov;
    if (!xs) begin
      u  = {1'b0, xa} + {1'b0, xb};
      s  = $signed({{2{xa[63]}}, xa}) + $signed({{2{xb[63]}}, xb});
      co = u[64];
    end else begin
      u  = {1'b0, xa} - {1'b0, xb};
      s  = $signed({{2{xa[63]}}, xa}) - $signed({{2{xb[63]}}, xb});
      co = (xa >= xb);
    end
    ov = (s != {{2{s[63]}}, s[63:0]});
    return {ov, co, u[63:0]};
  endfunction

  // Issue one operation and wait for done; cyc counts cycles after acceptance
  task automatic do_op(input logic [63:0] xa, input logic [63:0] xb, input logic xs,
                       output logic [63:0] r, output logic co, output logic ov,
                       output int cyc, output int nbusy);
    @(negedge clk);
    bus.start = 1'b1; bus.a = xa; bus.b = xb; bus.sub = xs;
    @(negedge clk);
    bus.start = 1'b0; bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom}; bus.sub = $urandom;
    cyc = 1; nbusy = 0;
    while (!bus.done && cyc < 40) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      cyc++;
    end
    r = bus.result; co = bus.carry_out; ov = bus.overflow;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b1; bus.a = '1; bus.b = '1; bus.sub = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow} !== 68'd0)
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h co=%b ov=%b, want all 0",
               bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow);
    else passed++;
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL reset_stays_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    else passed++;
  endtask

  task automatic test_add_latency();
    logic [63:0] r; logic co, ov; int cyc, nb;
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, r, co, ov, cyc, nb);
    checks++;
    if (cyc !== 5 || nb !== 4)
      $display("FAIL add_latency: got done at +%0d busy cycles %0d, want +5 and 4", cyc, nb);
    else passed++;
    checks++;
    if (r !== 64'h0 || co !== 1'b1 || ov !== 1'b0)
      $display("FAIL add_wrap: got %h co=%b ov=%b, want 0 co=1 ov=0", r, co, ov);
    else passed++;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.result !== 64'h0)
      $display("FAIL done_one_cycle: got done=%b result=%h, want done=0 result=0", bus.done, bus.result);
    else passed++;
  endtask

  task automatic test_sub();
    logic [63:0] r; logic co, ov; int cyc, nb;
    do_op(64'h0, 64'h1, 1'b1, r, co, ov, cyc, nb);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF || co !== 1'b0 || ov !== 1'b0)
      $display("FAIL sub_borrow: got %h co=%b ov=%b, want ffffffffffffffff co=0 ov=0", r, co, ov);
    else passed++;
    do_op(64'h5, 64'h3, 1'b1, r, co, ov, cyc, nb);
    checks++;
    if (r !== 64'h2 || co !== 1'b1)
      $display("FAIL sub_small: got %h co=%b, want 2 co=1", r, co);
    else passed++;
  endtask

  task automatic test_overflow();
    logic [63:0] r; logic co, ov; int cyc, nb;
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, r, co, ov, cyc, nb);
    checks++;
    if (r !== 64'h8000_0000_0000_0000 || ov !== 1'b1 || co !== 1'b0)
      $display("FAIL ovf_add: got %h co=%b ov=%b, want 8000000000000000 co=0 ov=1", r, co, ov);
    else passed++;
    do_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, r, co, ov, cyc, nb);
    checks++;
    if (r !== 64'h7FFF_FFFF_FFFF_FFFF || ov !== 1'b1 || co !== 1'b1)
      $display("FAIL ovf_sub: got %h co=%b ov=%b, want 7fffffffffffffff co=1 ov=1", r, co, ov);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 64'h0000_1111_2222_3333; bus.b = 64'h0000_0000_0000_0001; bus.sub = 1'b0;
    @(negedge clk);  // k+1
    bus.start = 1'b0;
    @(negedge clk);  // k+2: should be ignored
    bus.start = 1'b1; bus.a = 64'hDEAD_BEEF_0000_0000; bus.b = 64'h1; bus.sub = 1'b1;
    @(negedge clk);  // k+3
    bus.start = 1'b0;
    cyc = 3;
    while (!bus.done && cyc < 40) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc !== 5 || bus.result !== 64'h0000_1111_2222_3334)
      $display("FAIL start_in_run: got done at +%0d result=%h, want +5 result=0000111122223334", cyc, bus.result);
    else passed++;
    bus.start = 1'b1; bus.a = 64'h1234; bus.b = 64'h1; bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 40) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc !== 5 || bus.result !== 64'h1235 || bus.carry_out !== 1'b0)
      $display("FAIL back_to_back: got done at +%0d result=%h co=%b, want +5 result=1235 co=0",
               cyc, bus.result, bus.carry_out);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] r; logic co, ov; int cyc, nb; int seen_done;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 64'hFFFF_0000_FFFF_0000; bus.b = 64'h0001_0001_0001_0001; bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 64'h0)
      $display("FAIL reset_abort: got busy=%b done=%b result=%h, want 0 0 0", bus.busy, bus.done, bus.result);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    repeat (6) begin @(negedge clk); if (bus.done) seen_done++; end
    checks++;
    if (seen_done !== 0)
      $display("FAIL reset_no_done: got %0d done pulses, want 0", seen_done);
    else passed++;
    do_op(64'h0000_FFFF_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0, r, co, ov, cyc, nb);
    checks++;
    if (cyc !== 5 || r !== 64'h0001_0000_0000_0000 || co !== 1'b0 || ov !== 1'b0)
      $display("FAIL cross_carry: got +%0d %h co=%b ov=%b, want +5 0001000000000000 co=0 ov=0", cyc, r, co, ov);
    else passed++;
  endtask

  task automatic test_random();
    logic [63:0] xa, xb, r; logic xs, co, ov; int cyc, nb; logic [65:0] exp;
    for (int i = 0; i < 40; i++) begin
      xa = {$urandom, $urandom};
      xb = {$urandom, $urandom};
      if (i % 4 == 1) xb = ~xa;                       // long carry/borrow chains
      if (i % 4 == 2) xb = xa;
      if (i % 8 == 3) xa[63:48] = xb[63:48] ^ 16'h8000;
      xs = $urandom;
      exp = model(xa, xb, xs);
      do_op(xa, xb, xs, r, co, ov, cyc, nb);
      checks++;
      if (cyc !== 5 || r !== exp[63:0] || co !== exp[64] || ov !== exp[65])
        $display("FAIL random_%0d: a=%h b=%h sub=%b got +%0d %h co=%b ov=%b, want +5 %h co=%b ov=%b",
                 i, xa, xb, xs, cyc, r, co, ov, exp[63:0], exp[64], exp[65]);
      else passed++;
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    test_reset();
    test_add_latency();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
